// File: rtl/pc_gen.sv
// Fetch-PC generator: registered PC, advanced per accepted fetch, steered by prioritised redirects.
// Latency: pc_o registered; redirects/increments visible the cycle after they are taken.
// Backpressure: pc_ready_i low holds pc_o stable; hold_i freezes PC and latches redirects.
// Optional build macro PCGEN_PERF_EN adds redirect/hold event counters.
module pc_gen #(
    parameter int          ADDR_W     = 64,
    parameter int          NUM_REDIR  = 3,
    parameter logic [63:0] PC_INIT    = 64'h8000_0000,
    parameter int          INST_BYTES = 4,
    localparam int         SRC_W      = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hold_i,
    input  logic                        pc_ready_i,
    input  logic [NUM_REDIR-1:0]        redir_valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0] redir_pc_i,
    output logic [ADDR_W-1:0]           pc_o,
    output logic                        pc_valid_o,
    output logic                        redir_pending_o,
    output logic [SRC_W-1:0]            redir_src_o
`ifdef PCGEN_PERF_EN
    ,
    output logic [31:0]                 redir_cnt_o,
    output logic [31:0]                 hold_cnt_o
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(PC_INIT);
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INST_BYTES);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
    logic [SRC_W-1:0]    pend_src_q, pend_src_d;
    logic [SRC_W-1:0]    win_idx;
    logic [ADDR_W-1:0]   win_pc;
    logic                any_redir;
    logic                pend_take;

    // Pick the lowest-index active redirect channel.
    always_comb begin
        win_idx   = '0;
        win_pc    = '0;
        any_redir = |redir_valid_i;
        for (int k = NUM_REDIR - 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                win_idx = SRC_W'(k);
                win_pc  = redir_pc_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // A new redirect replaces the latched one when it is of equal or higher priority.
    assign pend_take = (state_q == PEND) && any_redir && (win_idx <= pend_src_q);

    // Next-state, next-PC and output decode.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pend_pc_d       = pend_pc_q;
        pend_src_d      = pend_src_q;
        pc_valid_o      = 1'b0;
        redir_pending_o = 1'b0;
        redir_src_o     = '0;
        case (state_q)
            BOOT, RUN: begin
                if (state_q == RUN) begin
                    pc_valid_o = !hold_i && !any_redir;
                end
                state_d = RUN;
                if (any_redir && !hold_i) begin
                    // Redirect wins over any in-flight request, accepted or not.
                    pc_d = win_pc;
                end else if (any_redir) begin
                    pend_pc_d  = win_pc;
                    pend_src_d = win_idx;
                    state_d    = PEND;
                end else if (pc_valid_o && pc_ready_i) begin
                    pc_d = pc_q + PC_INC;
                end
            end
            PEND: begin
                redir_pending_o = 1'b1;
                redir_src_o     = pend_src_q;
                if (pend_take) begin
                    pend_pc_d  = win_pc;
                    pend_src_d = win_idx;
                end
                if (!hold_i) begin
                    pc_d       = pend_pc_d;
                    state_d    = RUN;
                    pend_pc_d  = '0;
                    pend_src_d = '0;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= PC_RST;
            pend_pc_q  <= '0;
            pend_src_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_src_q <= pend_src_d;
        end
    end

    assign pc_o = pc_q;

`ifdef PCGEN_PERF_EN
    logic redir_inc;
    logic hold_inc;

    // Ignored lower-priority redirects during PEND are not counted.
    assign redir_inc = any_redir && ((state_q != PEND) || pend_take);
    assign hold_inc  = hold_i && ((state_q == RUN) || (state_q == PEND));

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            redir_cnt_o <= '0;
            hold_cnt_o  <= '0;
        end else begin
            if (redir_inc) redir_cnt_o <= redir_cnt_o + 32'd1;
            if (hold_inc)  hold_cnt_o  <= hold_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Registered fetch-PC generator for the IF stage.
- Holds the architectural fetch PC and advances it by INST_BYTES on each accepted fetch.
- Takes NUM_REDIR prioritised redirect channels (0 = CSR/trap, 1 = branch/jump, 2+ = future predictors).
- A redirect that arrives while fetch is held is latched, so it is never lost across pipeline stalls.

Parameters:
ADDR_W, 64, PC and target width in bits
NUM_REDIR, 3, number of redirect channels; index 0 has highest priority
PC_INIT, 64'h8000_0000, PC value loaded on reset (truncated to ADDR_W)
INST_BYTES, 4, sequential increment per accepted fetch

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
hold_i  input  1  pipeline hold; freezes PC, blocks issue of a fetch request
pc_ready_i  input  1  fetch unit accepts the current pc_o this cycle
redir_valid_i  input  NUM_REDIR  per-channel redirect request
redir_pc_i  input  NUM_REDIR*ADDR_W  per-channel target; channel k occupies bits [k*ADDR_W +: ADDR_W]
pc_o  output  ADDR_W  current fetch PC (registered)
pc_valid_o  output  1  pc_o is a live fetch request
redir_pending_o  output  1  a latched redirect is waiting for hold to drop
redir_src_o  output  $clog2(NUM_REDIR) or 1 if NUM_REDIR==1  index of the pending redirect; 0 when none

Behaviour:
- States: BOOT, RUN, PEND.
- Reset, any state, mid-operation included: state=BOOT, pc_o=PC_INIT, pending cleared, redir_pending_o=0, redir_src_o=0, pc_valid_o=0.
- BOOT:
  - pc_valid_o=0.
  - Next cycle: RUN; pc unchanged, unless a redirect is present (then handled as in RUN).
- Redirect select: winner = lowest index k with redir_valid_i[k]=1; any_redir = OR of redir_valid_i.
- pc_valid_o = (state==RUN) && !hold_i && !any_redir; combinational from registered state plus inputs.
- RUN, priority top-down:
  1. any_redir && !hold_i: pc <= winner target; stay RUN. Current request is dropped regardless of pc_ready_i.
  2. any_redir && hold_i: pending <= winner target, pending_src <= k; go PEND; pc unchanged.
  3. hold_i: pc unchanged.
  4. pc_valid_o && pc_ready_i: pc <= pc + INST_BYTES, modulo 2^ADDR_W. The all-ones-region wrap to 0 is legal.
  5. Otherwise: pc unchanged. The request stays asserted with a stable pc_o until accepted.
- PEND:
  - pc_valid_o=0; redir_pending_o=1; redir_src_o=pending_src.
  - New redirect with winner index k <= pending_src: overwrite pending target/src. Tie goes to the newer one.
  - New redirect with k > pending_src: ignored.
  - Overwrite applies whether hold_i is 0 or 1.
  - hold_i=0: pc <= pending target (after the overwrite rule above); go RUN; clear pending. pc_valid_o is 0 that cycle and 1 the next, if no hold or redirect.
  - hold_i=1: stay PEND.
- Targets are not alignment-checked; low bits pass through unchanged.
- No combinational path from pc_ready_i to pc_o.

Optional Feature:
- Macro: PCGEN_PERF_EN.
- Defined: adds outputs redir_cnt_o[31:0] and hold_cnt_o[31:0].
  - redir_cnt_o counts cycles where any_redir=1 and the redirect is applied or latched (not ignored).
  - hold_cnt_o counts cycles with hold_i=1 in RUN or PEND.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then release with hold_i=0 and pc_ready_i=1 constantly -> pc_valid_o=0 in the reset cycle and the BOOT cycle; pc_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 while valid=1.
- pc_ready_i=0 for 3 cycles at pc 0x8000_0010 -> pc_o stays 0x8000_0010, pc_valid_o=1 throughout; advances to 0x8000_0014 one cycle after ready=1.
- Same-cycle redir_valid_i=3'b110 with targets ch1=0x8000_1000, ch2=0x8000_2000, hold_i=0 -> pc_valid_o=0 that cycle; pc_o=0x8000_1000 next cycle.
- hold_i=1, then ch1 redirect to 0x1000, then ch0 to 0x2000, then ch2 to 0x3000, then hold_i=0:
  - redir_pending_o=1 with src 1, then src 0; stays 0 after the ch2 request.
  - pc_o=0x2000 one cycle after hold drops.
- pc at ADDR_W all-ones minus 3, accepted -> pc_o=0; reset asserted while in PEND -> pending cleared, pc_o=PC_INIT, redir_pending_o=0.
- PCGEN_PERF_EN defined, 2 applied redirects + 1 ignored ch2 in PEND + 4 hold cycles -> redir_cnt_o=2, hold_cnt_o=4.
